pll_scan_loader: RTL

Streams one PLL configuration image out of the serial config ROM and loads it into the PLL scan chain. It drives the ROM's `address`/`read_ena` and `pll_reconf_busy`, and buffers the returned bit stream. It then shifts the image into the PLL, issues `configupdate`, and waits for `scandone`. It sits between the mode-selected config ROM and the video PLL's reconfiguration port.

---
 rtl/pll_scan_pkg.sv | 21 ++
 rtl/pll_scan_shifter.sv | 66 ++++++
 rtl/pll_scan_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pll_scan_pkg.sv
// Shared types and default sizing for the PLL scan-chain loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_WAIT_RECONF,
        ST_SHIFT,
        ST_UPDATE,
        ST_WAIT_DONE
    } state_t;

    localparam int DEF_SCAN_BITS      = 144;
    localparam int DEF_ADDR_WIDTH     = 8;
    localparam int DEF_ROM_LATENCY    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1023;

endpackage

// File: rtl/pll_scan_shifter.sv
// Shadow register for one scan image, filled LSB-first from the ROM stream, then shifted out bit 0 first.
// Latency: scanclkena rises the cycle after start; each bit takes 2 cycles (low phase, high phase).
// Backpressure: none; load/start are single-cycle strobes and done flags the final high phase.
module pll_scan_shifter
    import pll_scan_pkg::*;
#(
    parameter int SCAN_BITS = DEF_SCAN_BITS
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic load_dat,
    input  logic start,
    output logic done,
    output logic scandata,
    output logic scanclk,
    output logic scanclkena
);

    localparam int CW = $clog2(SCAN_BITS + 1);

    logic [SCAN_BITS-1:0] shadow;
    logic [CW-1:0]        bit_cnt;
    logic                 phase_b;

    // The last high phase of the last bit ends the shift.
    assign done = scanclkena && phase_b && (bit_cnt == CW'(SCAN_BITS - 1));

    // Shadow fill, then 2-phase scan clock: data changes with scanclk low, PLL samples on the rise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow     <= '0;
            bit_cnt    <= '0;
            phase_b    <= 1'b0;
            scandata   <= 1'b0;
            scanclk    <= 1'b0;
            scanclkena <= 1'b0;
        end else if (start) begin
            scandata   <= shadow[0];
            shadow     <= {1'b0, shadow[SCAN_BITS-1:1]};
            bit_cnt    <= '0;
            phase_b    <= 1'b0;
            scanclk    <= 1'b0;
            scanclkena <= 1'b1;
        end else if (scanclkena) begin
            if (!phase_b) begin
                scanclk <= 1'b1;
                phase_b <= 1'b1;
            end else if (done) begin
                scanclk    <= 1'b0;
                scanclkena <= 1'b0;
                phase_b    <= 1'b0;
            end else begin
                scandata <= shadow[0];
                shadow   <= {1'b0, shadow[SCAN_BITS-1:1]};
                scanclk  <= 1'b0;
                phase_b  <= 1'b0;
                bit_cnt  <= bit_cnt + 1'b1;
            end
        end else if (load) begin
            // Bit k arrives k-th, so after SCAN_BITS loads bit 0 sits at the LSB.
            shadow <= {load_dat, shadow[SCAN_BITS-1:1]};
        end
    end

endmodule

// File: rtl/pll_scan_loader.sv
// Reads one PLL image from the config ROM, shifts it into the PLL scan chain and pulses configupdate.
// Latency: ~3*SCAN_BITS+ROM_LATENCY+5 cycles trigger->configupdate plus the rom_reconfig wait.
// Backpressure: triggers outside IDLE are dropped; waits on rom_reconfig/scandone (watchdog with PLL_SCAN_TIMEOUT_EN).
module pll_scan_loader
    import pll_scan_pkg::*;
#(
    parameter int SCAN_BITS      = DEF_SCAN_BITS,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int ROM_LATENCY    = DEF_ROM_LATENCY,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  trigger_read,
    input  logic                  rom_q,
    input  logic                  rom_reconfig,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read_ena,
    output logic                  pll_reconf_busy,
    output logic                  scandata,
    output logic                  scanclk,
    output logic                  scanclkena,
    output logic                  configupdate,
    input  logic                  scandone,
    output logic                  error
);

    localparam int DW = $clog2(ROM_LATENCY + 1);

    if (SCAN_BITS > (1 << ADDR_WIDTH)) begin : g_chk_addr
        $error("SCAN_BITS does not fit in the ROM address space");
    end
    if (ROM_LATENCY < 1) begin : g_chk_lat
        $error("ROM_LATENCY must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_to
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                 state, nxt_state;
    logic [ADDR_WIDTH-1:0]  nxt_address;
    logic                   nxt_read_ena;
    logic                   nxt_cfgupd;
    logic                   nxt_error;
    logic                   shift_start;
    logic                   shift_done;
    logic [DW-1:0]          drain_cnt;
    logic                   upd_phase;
    logic                   recfg_seen;
    logic                   scandone_q;
    logic [ROM_LATENCY-1:0] cap_pipe;
    logic                   wd_hit;

`ifdef PLL_SCAN_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;
    logic          waiting;

    assign waiting = (state == ST_WAIT_RECONF) || (state == ST_WAIT_DONE);
    assign wd_hit  = waiting && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

    // Watchdog counts consecutive cycles spent in either wait state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) wd_cnt <= '0;
        else          wd_cnt <= waiting ? wd_cnt + 1'b1 : '0;
    end
`else
    assign wd_hit = 1'b0;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        nxt_state    = state;
        nxt_address  = '0;
        nxt_read_ena = 1'b0;
        nxt_cfgupd   = 1'b0;
        nxt_error    = error;
        shift_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trigger_read) begin
                    nxt_state    = ST_READ;
                    nxt_read_ena = 1'b1;
                    nxt_error    = 1'b0;
                end
            end
            ST_READ: begin
                if (address == ADDR_WIDTH'(SCAN_BITS - 1)) begin
                    nxt_state = ST_DRAIN;
                end else begin
                    nxt_read_ena = 1'b1;
                    nxt_address  = address + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DW'(ROM_LATENCY - 1)) nxt_state = ST_WAIT_RECONF;
            end
            ST_WAIT_RECONF: begin
                if (rom_reconfig || recfg_seen) begin
                    nxt_state   = ST_SHIFT;
                    shift_start = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (shift_done) nxt_state = ST_UPDATE;
            end
            ST_UPDATE: begin
                // First cycle: scan clock parked low; second cycle: configupdate high.
                if (!upd_phase) nxt_cfgupd = 1'b1;
                else            nxt_state  = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (scandone && !scandone_q) nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
        if (wd_hit) begin
            nxt_state   = ST_IDLE;
            nxt_error   = 1'b1;
            shift_start = 1'b0;
        end
    end

    // State, outputs and small sequencing counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            address         <= '0;
            read_ena        <= 1'b0;
            pll_reconf_busy <= 1'b0;
            configupdate    <= 1'b0;
            error           <= 1'b0;
            drain_cnt       <= '0;
            upd_phase       <= 1'b0;
            recfg_seen      <= 1'b0;
            scandone_q      <= 1'b0;
        end else begin
            state           <= nxt_state;
            address         <= nxt_address;
            read_ena        <= nxt_read_ena;
            pll_reconf_busy <= (nxt_state != ST_IDLE);
            configupdate    <= nxt_cfgupd;
            error           <= nxt_error;
            drain_cnt       <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
            upd_phase       <= (state == ST_UPDATE) && !upd_phase;
            scandone_q      <= scandone;
            // An early end-of-read pulse during DRAIN is remembered for WAIT_RECONF.
            if (state == ST_DRAIN)           recfg_seen <= recfg_seen | rom_reconfig;
            else if (state != ST_WAIT_RECONF) recfg_seen <= 1'b0;
        end
    end

    // Delays read_ena by the ROM latency so rom_q is captured exactly when valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_pipe <= '0;
        end else begin
            cap_pipe[0] <= read_ena;
            for (int i = 1; i < ROM_LATENCY; i++) cap_pipe[i] <= cap_pipe[i-1];
        end
    end

    pll_scan_shifter #(
        .SCAN_BITS (SCAN_BITS)
    ) u_shifter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (cap_pipe[ROM_LATENCY-1]),
        .load_dat   (rom_q),
        .start      (shift_start),
        .done       (shift_done),
        .scandata   (scandata),
        .scanclk    (scanclk),
        .scanclkena (scanclkena)
    );

endmodule
